// File: rtl/vertical_dwt_row_scheduler.sv
// Row scheduler for the vertical 9/7 DWT: passes the horizontal-DWT stream
// into the vertical datapath, tags each beat with row/column information and
// appends synthetic flush rows so the lifting pipeline can drain.
module vertical_dwt_row_scheduler #(
  parameter int MaximumSideSize = 512,
  parameter int FlushRows       = 2,
  localparam int AW             = $clog2(MaximumSideSize)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [AW-1:0] side_size_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  input  logic          s_valid_i,
  output logic          s_ready_o,
  input  logic          s_eol_i,
  output logic          m_valid_o,
  input  logic          m_ready_i,
  output logic          m_eol_o,
  output logic [AW-1:0] row_o,
  output logic          first_row_o,
  output logic          last_row_o,
  output logic          flush_o,
  output logic [AW-1:0] col_addr_o,
  output logic          overflow_o
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  localparam logic [1:0]    LastFlush = 2'(FlushRows - 1);
  localparam logic [AW-1:0] ColMax    = AW'(MaximumSideSize - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, col_q, width_q, rows_q;
  logic [1:0]    flush_cnt_q;
  logic          overflow_q, done_q;
  logic          handshake, done_set;
  logic          row_is_last, col_at_width;

  assign row_is_last  = (row_q == rows_q - AW'(1));
  assign col_at_width = (col_q == width_q);

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign overflow_o  = overflow_q;
  assign col_addr_o  = col_q;
  assign row_o       = (state_q == FLUSH) ? rows_q + AW'(flush_cnt_q) : row_q;
  assign first_row_o = (state_q != FLUSH) && (row_q == '0);
  assign last_row_o  = (state_q != FLUSH) && row_is_last;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and handshake steering for each phase
  always_comb begin
    state_d   = state_q;
    s_ready_o = 1'b0;
    m_valid_o = 1'b0;
    m_eol_o   = 1'b0;
    flush_o   = 1'b0;
    handshake = 1'b0;
    done_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        m_valid_o = s_valid_i;
        s_ready_o = m_ready_i;
        m_eol_o   = s_eol_i;
        handshake = s_valid_i & m_ready_i;
        if (handshake && s_eol_i && row_is_last) state_d = FLUSH;
      end
      FLUSH: begin
        m_valid_o = 1'b1;
        flush_o   = 1'b1;
        m_eol_o   = col_at_width;
        handshake = m_ready_i;
        if (handshake && col_at_width && (flush_cnt_q == LastFlush)) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Row/column counters, tile geometry, sticky overflow and done pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q       <= '0;
      col_q       <= '0;
      width_q     <= '0;
      rows_q      <= '0;
      flush_cnt_q <= '0;
      overflow_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= done_set;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            rows_q      <= (side_size_i < AW'(2)) ? AW'(2) : side_size_i;
            row_q       <= '0;
            col_q       <= '0;
            flush_cnt_q <= '0;
            overflow_q  <= 1'b0;
          end
        end
        RUN: begin
          if (handshake) begin
            if (s_eol_i) begin
              width_q <= col_q;
              col_q   <= '0;
              if (row_is_last) flush_cnt_q <= '0;
              else             row_q       <= row_q + AW'(1);
            end else if (col_q == ColMax) begin
              col_q      <= '0;
              overflow_q <= 1'b1;
            end else begin
              col_q <= col_q + AW'(1);
            end
          end
        end
        FLUSH: begin
          if (handshake) begin
            if (col_at_width) begin
              col_q       <= '0;
              flush_cnt_q <= flush_cnt_q + 2'd1;
            end else begin
              col_q <= col_q + AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vertical_dwt_row_scheduler.sv
// Directed self-checking bench for vertical_dwt_row_scheduler (8x8 max tile,
// two flush rows). Inputs change on the falling edge; outputs are sampled
// 1 ns later, well away from the rising edge.
module tb_vertical_dwt_row_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] side_size = '0;
  logic       start = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_eol = 1'b0;
  logic       m_ready = 1'b0;
  logic       busy, done, s_ready, m_valid, m_eol, first_row, last_row, flush, overflow;
  logic [2:0] row, col_addr;

  int checks = 0;
  int errors = 0;

  // Packed view of the per-beat interface: valid, ready, eol, row, first, last, flush, col
  logic [11:0] obs;
  logic [11:0] expv;
  assign obs = {m_valid, s_ready, m_eol, row, first_row, last_row, flush, col_addr};

  vertical_dwt_row_scheduler #(.MaximumSideSize(8), .FlushRows(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .side_size_i(side_size), .start_i(start),
    .busy_o(busy), .done_o(done), .s_valid_i(s_valid), .s_ready_o(s_ready),
    .s_eol_i(s_eol), .m_valid_o(m_valid), .m_ready_i(m_ready), .m_eol_o(m_eol),
    .row_o(row), .first_row_o(first_row), .last_row_o(last_row), .flush_o(flush),
    .col_addr_o(col_addr), .overflow_o(overflow)
  );

  // Free-running clock, 10 ns period
  always #5 clk = ~clk;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_eol = 1'b0; m_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic do_start(input logic [2:0] sz);
    side_size = sz; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    s_valid = 1'b1; m_ready = 1'b1;
    @(negedge clk); #1;
    checks++;
    if ({busy, done, overflow, m_valid, s_ready} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_state: got %b expected 00000", {busy, done, overflow, m_valid, s_ready});
    end
    rst_n = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    do_reset();
    do_start(3'd4);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy: got %b expected 1", busy); end
    m_ready = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        s_valid = 1'b1; s_eol = (c == 2); #1;
        expv = {1'b1, 1'b1, (c == 2), 3'(r), (r == 0), (r == 3), 1'b0, 3'(c)};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("[TB] FAIL basic_run r%0d c%0d: got %b expected %b", r, c, obs, expv);
        end
        @(negedge clk);
      end
    end
    s_valid = 1'b0; s_eol = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 3; c++) begin
        #1;
        expv = {1'b1, 1'b0, (c == 2), 3'(4 + f), 1'b0, 1'b0, 1'b1, 3'(c)};
        checks++;
        if (obs !== expv) begin
          errors++;
          $display("[TB] FAIL basic_flush f%0d c%0d: got %b expected %b", f, c, obs, expv);
        end
        @(negedge clk);
      end
    end
    #1;
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("[TB] FAIL basic_done: got %b expected 10", {done, busy}); end
    @(negedge clk); #1;
    checks++;
    if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b expected 0", done); end
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stalls();
    do_reset();
    do_start(3'd3);
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 5; c++) begin
        for (int t = 0; t < 8; t++) begin
          logic sv, mr;
          sv = (t >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
          mr = (t >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
          s_valid = sv; m_ready = mr; s_eol = (c == 4); #1;
          expv = {sv, mr, (c == 4), 3'(r), (r == 0), (r == 2), 1'b0, 3'(c)};
          checks++;
          if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL stall_run r%0d c%0d t%0d: got %b expected %b", r, c, t, obs, expv);
          end
          @(negedge clk);
          if (sv && mr) break;
        end
      end
    end
    s_valid = 1'b0; s_eol = 1'b0;
    for (int f = 0; f < 2; f++) begin
      for (int c = 0; c < 5; c++) begin
        for (int t = 0; t < 8; t++) begin
          logic mr;
          mr = (t >= 6) ? 1'b1 : 1'($urandom_range(0, 1));
          m_ready = mr; #1;
          expv = {1'b1, 1'b0, (c == 4), 3'(3 + f), 1'b0, 1'b0, 1'b1, 3'(c)};
          checks++;
          if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL stall_flush f%0d c%0d t%0d: got %b expected %b", f, c, t, obs, expv);
          end
          @(negedge clk);
          if (mr) break;
        end
      end
    end
    #1;
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("[TB] FAIL stall_done: got %b expected 10", {done, busy}); end
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_small_side();
    for (int sz = 0; sz < 2; sz++) begin
      do_reset();
      do_start(3'(sz));
      m_ready = 1'b1;
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 2; c++) begin
          s_valid = 1'b1; s_eol = (c == 1); #1;
          expv = {1'b1, 1'b1, (c == 1), 3'(r), (r == 0), (r == 1), 1'b0, 3'(c)};
          checks++;
          if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL small_run sz%0d r%0d c%0d: got %b expected %b", sz, r, c, obs, expv);
          end
          @(negedge clk);
        end
      end
      s_valid = 1'b0; s_eol = 1'b0;
      for (int f = 0; f < 2; f++) begin
        for (int c = 0; c < 2; c++) begin
          #1;
          expv = {1'b1, 1'b0, (c == 1), 3'(2 + f), 1'b0, 1'b0, 1'b1, 3'(c)};
          checks++;
          if (obs !== expv) begin
            errors++;
            $display("[TB] FAIL small_flush sz%0d f%0d c%0d: got %b expected %b", sz, f, c, obs, expv);
          end
          @(negedge clk);
        end
      end
      #1;
      checks++;
      if ({done, busy} !== 2'b10) begin errors++; $display("[TB] FAIL small_done sz%0d: got %b expected 10", sz, {done, busy}); end
      m_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    do_start(3'd2);
    m_ready = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      s_eol = (k == 8); #1;
      checks++;
      if ({col_addr, overflow} !== {3'(k % 8), (k >= 8)}) begin
        errors++;
        $display("[TB] FAIL overflow_wrap k%0d: got %b expected %b", k, {col_addr, overflow}, {3'(k % 8), (k >= 8)});
      end
      @(negedge clk);
    end
    s_eol = 1'b1; #1;
    expv = {1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 3'd0};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL overflow_row1: got %b expected %b", obs, expv); end
    @(negedge clk);
    s_valid = 1'b0; s_eol = 1'b0;
    for (int f = 0; f < 2; f++) begin
      #1;
      expv = {1'b1, 1'b0, 1'b1, 3'(2 + f), 1'b0, 1'b0, 1'b1, 3'd0};
      checks++;
      if (obs !== expv) begin errors++; $display("[TB] FAIL overflow_flush f%0d: got %b expected %b", f, obs, expv); end
      @(negedge clk);
    end
    #1;
    checks++;
    if ({done, busy, overflow} !== 3'b101) begin
      errors++;
      $display("[TB] FAIL overflow_sticky: got %b expected 101", {done, busy, overflow});
    end
    @(negedge clk);
    do_start(3'd3);
    #1;
    checks++;
    if ({busy, overflow} !== 2'b10) begin errors++; $display("[TB] FAIL overflow_clear: got %b expected 10", {busy, overflow}); end
    m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    do_start(3'd4);
    m_ready = 1'b1;
    for (int b = 0; b < 12; b++) begin
      s_valid = 1'b1; s_eol = ((b % 3) == 2);
      @(negedge clk);
    end
    s_valid = 1'b0; s_eol = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    expv = {1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 3'd2};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL midflush_pos: got %b expected %b", obs, expv); end
    s_valid = 1'b1; rst_n = 1'b0; #1;
    checks++;
    if ({busy, m_valid, s_ready} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL midflush_reset: got %b expected 000", {busy, m_valid, s_ready});
    end
    @(negedge clk);
    rst_n = 1'b1; s_valid = 1'b0;
    @(negedge clk);
    do_start(3'd4);
    s_valid = 1'b1; s_eol = 1'b0; #1;
    expv = {1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL midflush_restart: got %b expected %b", obs, expv); end
    @(negedge clk);
  endtask

  task automatic test_start_ignored();
    do_reset();
    do_start(3'd2);
    m_ready = 1'b1; s_valid = 1'b1; s_eol = 1'b1;
    start = 1'b1; side_size = 3'd6; #1;
    expv = {1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL ignore_run_r0: got %b expected %b", obs, expv); end
    @(negedge clk);
    start = 1'b0; #1;
    expv = {1'b1, 1'b1, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0, 3'd0};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL ignore_run_r1: got %b expected %b", obs, expv); end
    @(negedge clk);
    s_valid = 1'b0; s_eol = 1'b0; #1;
    expv = {1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 3'd0};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL ignore_flush0: got %b expected %b", obs, expv); end
    @(negedge clk);
    start = 1'b1; side_size = 3'd3; #1;
    expv = {1'b1, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 3'd0};
    checks++;
    if (obs !== expv) begin errors++; $display("[TB] FAIL ignore_flush1: got %b expected %b", obs, expv); end
    @(negedge clk);
    #1;
    checks++;
    if ({done, busy} !== 2'b10) begin errors++; $display("[TB] FAIL ignore_done_cycle: got %b expected 10", {done, busy}); end
    @(negedge clk);
    start = 1'b0; #1;
    checks++;
    if ({done, busy} !== 2'b01) begin errors++; $display("[TB] FAIL ignore_accept: got %b expected 01", {done, busy}); end
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      s_valid = 1'b1; s_eol = 1'b1; #1;
      expv = {1'b1, 1'b1, 1'b1, 3'(r), (r == 0), (r == 2), 1'b0, 3'd0};
      checks++;
      if (obs !== expv) begin errors++; $display("[TB] FAIL ignore_new_tile r%0d: got %b expected %b", r, obs, expv); end
      @(negedge clk);
    end
    s_valid = 1'b0; s_eol = 1'b0; m_ready = 1'b0;
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_small_side();
    test_overflow();
    test_reset_mid_flush();
    test_start_ignored();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
